// File: rtl/mem_arbiter_rr.sv
// Round-robin arbiter granting one requester at a time access to a shared memory line port.
// Three-state FSM (IDLE/GRANT/TURN) with bounded hold time and a one-cycle bus turnaround.
module mem_arbiter_rr #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned LINE_W   = 66,
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            we_req,
  input  logic [NUM_REQ*LINE_W-1:0]     wline_in,
  input  logic [LINE_W-1:0]             read_line,
  output logic [LINE_W-1:0]             rline_out,
  output logic [LINE_W-1:0]             write_line,
  output logic                          we,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [$clog2(NUM_REQ)-1:0]    owner_id,
  output logic                          busy
);

  localparam int unsigned IDW      = $clog2(NUM_REQ);
  localparam logic [7:0]  HOLD_MAX = 8'(MAX_HOLD - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [IDW-1:0]       owner_q, owner_d;
  logic [IDW-1:0]       last_q, last_d;
  logic [7:0]           hold_q, hold_d;
  logic [IDW-1:0]       winner;
  logic [IDW-1:0]       cand;
  logic                 win_vld;
  logic                 others;

  // Search starts just after the previous owner so the previous owner is considered last.
  always_comb begin
    winner  = '0;
    cand    = '0;
    win_vld = 1'b0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = IDW'((32'(last_q) + k) % NUM_REQ);
      if (!win_vld && req[cand]) begin
        win_vld = 1'b1;
        winner  = cand;
      end
    end
  end

  assign others = |(req & ~gnt_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      owner_q <= '0;
      last_q  <= IDW'(NUM_REQ - 1);
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    last_d  = last_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE, TURN: begin
        gnt_d   = '0;
        state_d = IDLE;
        if (win_vld) begin
          state_d = GRANT;
          gnt_d   = {{(NUM_REQ-1){1'b0}}, 1'b1} << winner;
          owner_d = winner;
          last_d  = winner;
          hold_d  = '0;
        end
      end
      GRANT: begin
        if (!req[owner_q]) begin
          gnt_d   = '0;
          state_d = others ? TURN : IDLE;
        end else if (others && hold_q == HOLD_MAX) begin
          gnt_d   = '0;
          state_d = TURN;
        end else if (hold_q != HOLD_MAX) begin
          hold_d = hold_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        hold_d  = '0;
      end
    endcase
  end

  always_comb begin
    gnt        = gnt_q;
    busy       = |gnt_q;
    owner_id   = owner_q;
    we         = busy & we_req[owner_q];
    write_line = we ? wline_in[32'(owner_q)*LINE_W +: LINE_W] : '0;
    rline_out  = busy ? read_line : '0;
  end

endmodule
